// File: rtl/axis_axil_cmd_unpack.sv
// Unpacks AXI-Stream command packets into single AXI-Lite requests on a cmd_* handshake.
// Read data from the master returns as single-beat stream packets. Malformed packets are dropped and counted.
module axis_axil_cmd_unpack #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int MAX_RD_OUTST = 4
) (
  input  logic              axi_clk,
  input  logic              axi_reset,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic [DATA_W/8-1:0] cmd_wstrb,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [15:0]       err_cnt
);

  typedef enum logic [1:0] {HDR, DATA, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic                op;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
  } cmd_t;

  state_t            r_state;
  state_t            w_state_nxt;
  cmd_t              r_cmd;
  logic              r_s_tready;
  logic              r_cmd_valid;
  logic [3:0]        r_rd_outst;
  logic [3:0]        w_rd_outst_nxt;
  logic [15:0]       r_err_cnt;
  logic [DATA_W-1:0] r_m_tdata;
  logic              r_m_tvalid;

  logic w_s_hs, w_cmd_hs, w_m_hs, w_rsp_hs, w_rd_inc;
  logic w_err, w_hdr_ok, w_op_nxt;

  assign w_s_hs   = s_tvalid & r_s_tready;
  assign w_cmd_hs = r_cmd_valid & cmd_ready;
  assign w_m_hs   = r_m_tvalid & m_tready;
  assign w_rsp_hs = rsp_valid & rsp_ready;
  assign w_rd_inc = w_cmd_hs & ~r_cmd.op;

  // Only well-formed headers overwrite the captured command.
  assign w_hdr_ok = (r_state == HDR) & w_s_hs & (s_tdata[31] ^ s_tlast);
  assign w_op_nxt = w_hdr_ok ? s_tdata[31] : r_cmd.op;

  always_comb begin
    w_rd_outst_nxt = r_rd_outst;
    if (w_rd_inc && !w_m_hs)      w_rd_outst_nxt = r_rd_outst + 4'd1;
    else if (!w_rd_inc && w_m_hs) w_rd_outst_nxt = r_rd_outst - 4'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    unique case (r_state)
      HDR: if (w_s_hs) begin
        unique case ({s_tdata[31], s_tlast})
          2'b01: w_state_nxt = ISSUE;
          2'b10: w_state_nxt = DATA;
          2'b00: begin w_state_nxt = DRAIN; w_err = 1'b1; end
          2'b11: begin w_state_nxt = HDR;   w_err = 1'b1; end
        endcase
      end
      DATA: if (w_s_hs) begin
        if (s_tlast) w_state_nxt = ISSUE;
        else begin
          w_state_nxt = DRAIN;
          w_err       = 1'b1;
        end
      end
      DRAIN: if (w_s_hs && s_tlast) w_state_nxt = HDR;
      ISSUE: if (w_cmd_hs)          w_state_nxt = HDR;
      default: w_state_nxt = HDR;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      r_state     <= HDR;
      r_s_tready  <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
      r_rd_outst  <= '0;
      r_err_cnt   <= '0;
      r_m_tdata   <= '0;
      r_m_tvalid  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_s_tready <= (w_state_nxt != ISSUE);
      r_rd_outst <= w_rd_outst_nxt;
      // A read waiting on the outstanding limit keeps cmd_valid low until a response drains.
      r_cmd_valid <= (w_state_nxt == ISSUE) &&
                     (w_op_nxt || (w_rd_outst_nxt < 4'(MAX_RD_OUTST)));

      if (w_hdr_ok) begin
        r_cmd.op    <= s_tdata[31];
        r_cmd.addr  <= s_tdata[ADDR_W-1:0];
        r_cmd.wstrb <= s_tdata[31] ? s_tdata[27:24] : '0;
        r_cmd.wdata <= '0;
      end else if (r_state == DATA && w_s_hs) begin
        r_cmd.wdata <= s_tdata;
      end

      if (w_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;

      if (w_rsp_hs) begin
        r_m_tdata  <= rsp_rdata;
        r_m_tvalid <= 1'b1;
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign s_tready  = r_s_tready;
  assign cmd_valid = r_cmd_valid;
  assign cmd_op    = r_cmd.op;
  assign cmd_addr  = r_cmd.addr;
  assign cmd_wdata = r_cmd.wdata;
  assign cmd_wstrb = r_cmd.wstrb;
  assign rsp_ready = ~r_m_tvalid | m_tready;
  assign m_tdata   = r_m_tdata;
  assign m_tvalid  = r_m_tvalid;
  assign m_tlast   = r_m_tvalid;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_axis_axil_cmd_unpack.sv
// Directed bench for axis_axil_cmd_unpack: inputs change and outputs are sampled 1ns after each rising edge.
module tb_axis_axil_cmd_unpack;
  localparam int ADDR_W = 15;

  logic              axi_clk = 1'b0;
  logic              axi_reset;
  logic [31:0]       s_tdata;
  logic              s_tlast, s_tvalid, s_tready;
  logic              cmd_valid, cmd_ready, cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_rdata, m_tdata;
  logic              m_tlast, m_tvalid, m_tready;
  logic [15:0]       err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 axi_clk = ~axi_clk;

  axis_axil_cmd_unpack #(.ADDR_W(ADDR_W), .DATA_W(32), .MAX_RD_OUTST(4)) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_tready"},  s_tready,  0);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_cmd_op"},    cmd_op,    0);
    chk({tag, "_cmd_addr"},  cmd_addr,  0);
    chk({tag, "_cmd_wdata"}, cmd_wdata, 0);
    chk({tag, "_cmd_wstrb"}, cmd_wstrb, 0);
    chk({tag, "_rsp_ready"}, rsp_ready, 1);
    chk({tag, "_m_tvalid"},  m_tvalid,  0);
    chk({tag, "_m_tdata"},   m_tdata,   0);
    chk({tag, "_m_tlast"},   m_tlast,   0);
    chk({tag, "_err_cnt"},   err_cnt,   0);
  endtask

  initial begin
    axi_reset = 1'b1; s_tdata = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; m_tready = 1'b1;
    tick(); tick();
    chk_reset_vals("rst");
    axi_reset = 1'b0;
    tick();
    chk("hdr_ready", s_tready, 1);

    // Read packet, then 5 cycles of back-pressure on cmd_ready
    beat(32'h0000_0104, 1'b1);
    tick();
    s_tvalid = 1'b0;
    chk("rd_valid", cmd_valid, 1);
    chk("rd_op",    cmd_op,    0);
    chk("rd_addr",  cmd_addr,  15'h104);
    chk("rd_wstrb", cmd_wstrb, 0);
    chk("rd_wdata", cmd_wdata, 0);
    beat(32'h0000_0200, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", cmd_valid, 1);
      chk("hold_addr",  cmd_addr,  15'h104);
      chk("hold_sready", s_tready, 0);
    end
    cmd_ready = 1'b1;
    tick();
    chk("hs_valid",  cmd_valid, 0);
    chk("hs_sready", s_tready,  1);
    tick();
    s_tvalid = 1'b0;
    chk("b2b_valid", cmd_valid, 1);
    chk("b2b_addr",  cmd_addr,  15'h200);
    tick();
    chk("b2b_done", cmd_valid, 0);

    // Drain the two outstanding reads through the response path
    rsp_valid = 1'b1; rsp_rdata = 32'h0000_00AA;
    tick();
    chk("r1_tvalid", m_tvalid, 1);
    chk("r1_tdata",  m_tdata,  32'hAA);
    chk("r1_tlast",  m_tlast,  1);
    rsp_rdata = 32'h0000_00BB;
    tick();
    rsp_valid = 1'b0;
    chk("r2_tdata", m_tdata, 32'hBB);
    tick();
    chk("r2_empty", m_tvalid, 0);

    // Write packet
    cmd_ready = 1'b0;
    beat(32'h8F00_0020, 1'b0);
    tick();
    chk("wr_hdr_novalid", cmd_valid, 0);
    chk("wr_hdr_sready",  s_tready,  1);
    beat(32'hDEAD_BEEF, 1'b1);
    tick();
    s_tvalid = 1'b0;
    chk("wr_valid", cmd_valid, 1);
    chk("wr_op",    cmd_op,    1);
    chk("wr_addr",  cmd_addr,  15'h20);
    chk("wr_wstrb", cmd_wstrb, 4'hF);
    chk("wr_wdata", cmd_wdata, 32'hDEAD_BEEF);
    cmd_ready = 1'b1;
    tick();
    chk("wr_done", cmd_valid, 0);

    // Malformed: write header alone, then read header followed by two beats
    beat(32'h8F00_0040, 1'b1);
    tick();
    chk("bad1_err",   err_cnt,   1);
    chk("bad1_valid", cmd_valid, 0);
    beat(32'h0000_0050, 1'b0);
    tick();
    chk("bad2_err", err_cnt, 2);
    beat(32'h8F00_0060, 1'b0);
    tick();
    chk("drain1_valid", cmd_valid, 0);
    beat(32'h1234_5678, 1'b1);
    tick();
    chk("drain2_valid", cmd_valid, 0);
    chk("drain2_err",   err_cnt,   2);
    beat(32'h0000_0070, 1'b1);
    tick();
    s_tvalid = 1'b0;
    chk("after_bad_valid", cmd_valid, 1);
    chk("after_bad_addr",  cmd_addr,  15'h70);
    tick();
    rsp_valid = 1'b1; rsp_rdata = 32'h0;
    tick();
    rsp_valid = 1'b0;
    tick();
    chk("after_bad_drained", m_tvalid, 0);

    // Outstanding limit: four reads issue, the fifth is held
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(32'h0000_0100 + 32'(i), 1'b1);
      tick();
      s_tvalid = 1'b0;
      chk("outst_valid", cmd_valid, 1);
      tick();
    end
    beat(32'h0000_0300, 1'b1);
    tick();
    s_tvalid = 1'b0;
    chk("limit_valid",  cmd_valid, 0);
    chk("limit_sready", s_tready,  0);
    tick();
    chk("limit_valid2", cmd_valid, 0);
    rsp_valid = 1'b1; rsp_rdata = 32'h11;
    tick();
    chk("rsp11_tvalid", m_tvalid,  1);
    chk("rsp11_tdata",  m_tdata,   32'h11);
    chk("rsp_stall",    rsp_ready, 0);
    rsp_rdata = 32'h22;
    tick();
    chk("rsp11_hold",   m_tdata,   32'h11);
    chk("limit_valid3", cmd_valid, 0);
    m_tready = 1'b1;
    tick();
    rsp_valid = 1'b0;
    chk("rsp22_tdata",  m_tdata,   32'h22);
    chk("rsp22_tlast",  m_tlast,   1);
    chk("unblock_valid", cmd_valid, 1);
    chk("unblock_addr",  cmd_addr,  15'h300);
    tick();
    chk("unblock_done", cmd_valid, 0);
    chk("rsp22_gone",   m_tvalid,  0);

    // Reset with a pending command and a held response
    cmd_ready = 1'b0; m_tready = 1'b0;
    beat(32'h8F00_0444, 1'b0);
    tick();
    beat(32'hCAFE_F00D, 1'b1);
    rsp_valid = 1'b1; rsp_rdata = 32'h55;
    tick();
    s_tvalid = 1'b0; rsp_valid = 1'b0;
    chk("pre_rst_cmd", cmd_valid, 1);
    chk("pre_rst_m",   m_tvalid,  1);
    axi_reset = 1'b1;
    tick();
    chk_reset_vals("midrst");
    axi_reset = 1'b0;
    tick();
    chk("post_rst_sready", s_tready,  1);
    chk("post_rst_valid",  cmd_valid, 0);
    beat(32'h0000_0008, 1'b1);
    tick();
    s_tvalid = 1'b0;
    chk("post_rst_rd",   cmd_valid, 1);
    chk("post_rst_addr", cmd_addr,  15'h8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
